axi_master_write_engine: RTL
============================

Name: axi_master_write_engine

Overview:
- Parametrised successor to the single-burst AXI write master; sits between the DMA-to-master async FIFO and the AXI interconnect.
- Accepts one transfer command (base address, total beat count) and splits it into multiple AXI INCR bursts. Bursts are capped by MAX_BURST_BEATS and never cross a 4 KB boundary.
- Drives AW, W and B channels with one burst outstanding at a time. Reports completion and a 2-bit worst-case response.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, W data width; power of two, 8..1024.
- LEN_WIDTH, 8, AWLEN width (8 = AXI4).
- TOTAL_WIDTH, 16, width of total-beat command field.
- MAX_BURST_BEATS, 16, burst cap; 1..2^LEN_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- target_write_addr  in  ADDR_WIDTH  byte base address; low log2(DATA_WIDTH/8) bits forced to 0.
- target_total_beats  in  TOTAL_WIDTH  total beats; 0 = no-op.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at transfer end.
- resp_status  out  2  worst BRESP of the transfer; held until next start.
- fifo_rdata  in  DATA_WIDTH  FIFO head data.
- fifo_rempty  in  1  FIFO empty.
- fifo_rpull  out  1  pop; equals WVALID&&WREADY.
- AWADDR  out  ADDR_WIDTH; AWVALID  out  1; AWREADY  in  1; AWLEN  out  LEN_WIDTH; AWSIZE  out  3; AWBURST  out  2.
- WDATA  out  DATA_WIDTH; WSTRB  out  DATA_WIDTH/8; WLAST  out  1; WVALID  out  1; WREADY  in  1.
- BRESP  in  2; BVALID  in  1; BREADY  out  1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; remaining, addr, beat counter and resp_status cleared. All VALID/READY, done, busy, fifo_rpull, WLAST = 0. AWADDR, AWLEN and WDATA = 0.
- Constant outputs: AWSIZE=log2(DATA_WIDTH/8); AWBURST=2'b01 (INCR); WSTRB all ones.
- IDLE: on start:
  - Latch the aligned address and the total beat count; clear resp_status.
  - If total=0, go to DONE; otherwise go to CALC.
  - start outside IDLE is ignored.
- CALC (1 cycle): burst_beats = min(remaining, MAX_BURST_BEATS, (4096 - addr[11:0]) >> AWSIZE). Register AWLEN = burst_beats-1. Go to AW.
- AW: AWVALID=1 with AWADDR/AWLEN stable until AWREADY. On handshake, go to W.
- W:
  - WVALID = !fifo_rempty; WDATA = fifo_rdata.
  - Counter increments per beat. WLAST=1 on beat index AWLEN.
  - On the WLAST beat: go to B, subtract burst_beats from remaining, and advance addr by burst_beats<<AWSIZE (wraps mod 2^ADDR_WIDTH).
  - WVALID never asserted before the AW handshake.
- B:
  - BREADY=1. On BVALID, resp_status = max(resp_status, BRESP); severity order OKAY(00) < EXOKAY(01) < SLVERR(10) < DECERR(11).
  - Then go to CALC if remaining!=0, else DONE.
- DONE: done=1 for one cycle; go to IDLE. start in the same cycle is ignored.
- Latency: first AWVALID 2 cycles after start. Each additional burst costs 1 CALC cycle after the B handshake.
- FIFO empty mid-burst: WVALID drops, no pop, the beat count holds. There is no timeout.
- WREADY high while WVALID low is not counted.
- Reset mid-transfer aborts immediately; no outstanding-transaction cleanup.

Optional Feature:
- Macro AXI_WR_ERR_ABORT_EN.
- Defined: a B handshake with BRESP[1]=1 (SLVERR/DECERR) goes to DONE regardless of remaining bursts. resp_status holds the error; unsent FIFO data is left in the FIFO.
- Undefined: errors are recorded in resp_status, and all remaining bursts are still issued.

Test Plan:
- addr=0x1000, total=40, MAX=16, FIFO always full, ready always 1 -> three bursts:
  - AWADDR 0x1000/0x1040/0x1080 with AWLEN 15/15/7;
  - 40 pops; WLAST on beats 16, 32, 40;
  - done pulse; resp_status=00.
- addr=0x0FF0, total=8 (DATA_WIDTH=32) -> bursts AWADDR 0x0FF0 AWLEN 3, then 0x1000 AWLEN 3; no 4 KB crossing.
- total=0 -> no AWVALID; done 2 cycles after start.
- FIFO empty for 5 cycles mid-burst and WREADY toggling 1/0 -> WVALID low while empty; data order preserved; beat count exact; WLAST only on the final beat.
- Second burst BRESP=2'b10, total=48:
  - without AXI_WR_ERR_ABORT_EN: 3 bursts issued, resp_status=10;
  - with it: done after burst 2, 32 pops, resp_status=10.
- rst_n low during W state -> all outputs at reset values asynchronously; the next start runs a clean transfer.

Source files
------------

// File: rtl/axi_master_write_engine.sv
// Splits one write command into AXI INCR bursts that never cross a 4 KB page, fed from a FIFO.
// Optional build macro AXI_WR_ERR_ABORT_EN: stop the transfer after the first SLVERR/DECERR response.
module axi_master_write_engine #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int TOTAL_WIDTH     = 16,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   target_write_addr,
    input  logic [TOTAL_WIDTH-1:0]  target_total_beats,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              resp_status,
    input  logic [DATA_WIDTH-1:0]   fifo_rdata,
    input  logic                    fifo_rempty,
    output logic                    fifo_rpull,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [LEN_WIDTH-1:0]    AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);
    localparam int BW         = LEN_WIDTH + 1;
    localparam int CW         = ((TOTAL_WIDTH > BW) ? TOTAL_WIDTH : BW) + 14;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                 state;
    logic [TOTAL_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [BW-1:0]          burst_beats;

    logic [12:0]            page_off;
    logic [CW-1:0]          room;
    logic [CW-1:0]          burst_calc;
    logic [ADDR_WIDTH-1:0]  addr_step;
    logic [1:0]             resp_next;

    assign AWSIZE  = 3'(SIZE);
    assign AWBURST = 2'b01;
    assign WSTRB   = '1;

    assign WVALID     = (state == S_W) && !fifo_rempty;
    assign WDATA      = (state == S_W) ? fifo_rdata : '0;
    assign WLAST      = (state == S_W) && (beat_cnt == AWLEN);
    assign BREADY     = (state == S_B);
    assign fifo_rpull = WVALID && WREADY;

    // Burst size is the tightest of: beats left, the burst cap, and beats left in the 4 KB page.
    always_comb begin
        page_off   = {1'b0, addr[11:0]};
        room       = CW'((13'h1000 - page_off) >> SIZE);
        burst_calc = CW'(remaining);
        if (CW'(MAX_BURST_BEATS) < burst_calc) burst_calc = CW'(MAX_BURST_BEATS);
        if (room < burst_calc) burst_calc = room;
        addr_step  = ADDR_WIDTH'(burst_beats) << SIZE;
        resp_next  = (BRESP > resp_status) ? BRESP : resp_status;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            remaining   <= '0;
            addr        <= '0;
            beat_cnt    <= '0;
            burst_beats <= '0;
            resp_status <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            AWVALID     <= 1'b0;
            AWADDR      <= '0;
            AWLEN       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr        <= target_write_addr & ALIGN_MASK;
                        remaining   <= target_total_beats;
                        resp_status <= 2'b00;
                        busy        <= 1'b1;
                        state       <= (target_total_beats == '0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    burst_beats <= BW'(burst_calc);
                    AWLEN       <= LEN_WIDTH'(burst_calc - CW'(1));
                    AWADDR      <= addr;
                    AWVALID     <= 1'b1;
                    beat_cnt    <= '0;
                    state       <= S_AW;
                end
                S_AW: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (fifo_rpull) begin
                        if (WLAST) begin
                            remaining <= remaining - TOTAL_WIDTH'(burst_beats);
                            addr      <= addr + addr_step;
                            state     <= S_B;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        resp_status <= resp_next;
`ifdef AXI_WR_ERR_ABORT_EN
                        state <= (BRESP[1] || remaining == '0) ? S_DONE : S_CALC;
`else
                        state <= (remaining == '0) ? S_DONE : S_CALC;
`endif
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
